matrix_bank: RTL and testbench

Parametrised multi-matrix element store for the matrix datapath: holds NUM_MAT matrices of up to MAX_DIM x MAX_DIM elements, with per-matrix dimension registers, bounds-checked element read/write, a hardware clear engine and a row-major streaming read port with valid/ready backpressure. It sits between the operand loader and the arithmetic units. It replaces ad-hoc element storage with a self-initialising, bounds-checked bank.

---
 rtl/matrix_pkg.sv | 24 ++
 rtl/matrix_bank_ram.sv | 25 ++
 rtl/matrix_bank.sv | 243 ++++++++++++++++++++++++
 tb/tb_matrix_bank.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix element bank: FSM states, default
// geometry and the flat-array address mapping.
package matrix_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM
    } state_t;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_MAX_DIM = 10;
    localparam int DEF_NUM_MAT = 3;

    // Matrices are laid out back to back, each a full MAX_DIM x MAX_DIM block.
    function automatic int unsigned mat_addr(input int unsigned max_dim,
                                             input int unsigned sel,
                                             input int unsigned row,
                                             input int unsigned col);
        return (sel * max_dim + row) * max_dim + col;
    endfunction

endpackage

// File: rtl/matrix_bank_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port whose output
// only changes on a read enable. Contents are not reset.
module matrix_bank_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 300,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read-before-write: a same-address read in the write cycle sees old data.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/matrix_bank.sv
// Multi-matrix element store: per-matrix dimensions, bounds-checked element
// access, self-initialisation, a clear engine and a row-major stream port.
module matrix_bank
    import matrix_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MAX_DIM = DEF_MAX_DIM,
    parameter int NUM_MAT = DEF_NUM_MAT,
    parameter int IDX_W   = 4,
    parameter int SEL_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SEL_W-1:0]  sel,
    input  logic [IDX_W-1:0]  row,
    input  logic [IDX_W-1:0]  col,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              cfg_en,
    input  logic [IDX_W-1:0]  cfg_rows,
    input  logic [IDX_W-1:0]  cfg_cols,
    input  logic              clr_req,
    input  logic              strm_start,
    output logic [DATA_W-1:0] strm_data,
    output logic              strm_valid,
    input  logic              strm_ready,
    output logic              strm_last,
    output logic              busy,
    output logic              err
);

    localparam int DEPTH  = NUM_MAT * MAX_DIM * MAX_DIM;
    localparam int ADDR_W = $clog2(DEPTH);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [IDX_W-1:0]  dim_rows [NUM_MAT];
    logic [IDX_W-1:0]  dim_cols [NUM_MAT];
    logic [SEL_W-1:0]  op_sel;
    logic [IDX_W-1:0]  op_rows, op_cols;
    logic [IDX_W-1:0]  s_r, s_c;
    logic              s_more, f_vld, f_last, rd_pend;

    logic              we, re;
    logic [ADDR_W-1:0] waddr, raddr;
    logic [DATA_W-1:0] wdata, ram_q;

    // Request decode
    logic              idle, sel_ok, idx_ok, cfg_ok, any_req;
    logic [SEL_W-1:0]  sel_i;
    logic [IDX_W-1:0]  cur_rows, cur_cols;
    logic              acc_clr, acc_strm, acc_cfg, elem_req, acc_elem, err_next;
    logic [ADDR_W-1:0] elem_addr, sel_base, op_base, strm_addr;

    assign idle     = (state == ST_IDLE);
    assign busy     = !idle;
    assign sel_ok   = (32'(sel) < NUM_MAT);
    assign sel_i    = sel_ok ? sel : '0;
    assign cur_rows = dim_rows[sel_i];
    assign cur_cols = dim_cols[sel_i];
    assign idx_ok   = (row < cur_rows) && (col < cur_cols);
    assign cfg_ok   = (cfg_rows != '0) && (cfg_cols != '0) &&
                      (cfg_rows <= IDX_W'(MAX_DIM)) && (cfg_cols <= IDX_W'(MAX_DIM));
    assign any_req  = clr_req | strm_start | cfg_en | wr_en | rd_en;

    assign acc_clr  = idle & clr_req & sel_ok;
    assign acc_strm = idle & !clr_req & strm_start & sel_ok;
    assign acc_cfg  = idle & !clr_req & !strm_start & cfg_en & sel_ok & cfg_ok;
    assign elem_req = idle & !clr_req & !strm_start & !cfg_en & (wr_en | rd_en);
    assign acc_elem = elem_req & sel_ok & idx_ok;

    assign err_next = (!idle & any_req)
                    | (idle & clr_req & !sel_ok)
                    | (idle & !clr_req & strm_start & !sel_ok)
                    | (idle & !clr_req & !strm_start & cfg_en & !(sel_ok & cfg_ok))
                    | (elem_req & !(sel_ok & idx_ok));

    assign elem_addr = ADDR_W'(mat_addr(MAX_DIM, 32'(sel), 32'(row), 32'(col)));
    assign sel_base  = ADDR_W'(mat_addr(MAX_DIM, 32'(sel), 0, 0));
    assign op_base   = ADDR_W'(mat_addr(MAX_DIM, 32'(op_sel), 0, 0));
    assign strm_addr = ADDR_W'(mat_addr(MAX_DIM, 32'(op_sel), 32'(s_r), 32'(s_c)));

    // Stream pipeline: ram_q is the fetch stage, strm_data the output stage.
    logic in_strm, out_load, out_fire, s_issue, s_lastpos;
    assign in_strm   = (state == ST_STREAM);
    assign out_fire  = strm_valid & strm_ready;
    assign out_load  = in_strm & f_vld & (!strm_valid | strm_ready);
    assign s_issue   = in_strm & s_more & (!f_vld | out_load);
    assign s_lastpos = (s_r == op_rows - 1'b1) && (s_c == op_cols - 1'b1);

    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        case (state)
            ST_INIT: begin
                we    = 1'b1;
                waddr = cnt;
            end
            ST_CLEAR: begin
                we    = 1'b1;
                waddr = op_base + cnt;
            end
            ST_IDLE: begin
                if (acc_elem && wr_en) begin
                    we    = 1'b1;
                    waddr = elem_addr;
                    wdata = wr_data;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        re    = 1'b0;
        raddr = elem_addr;
        if (acc_strm) begin
            re    = 1'b1;
            raddr = sel_base;
        end else if (s_issue) begin
            re    = 1'b1;
            raddr = strm_addr;
        end else if (acc_elem && rd_en) begin
            re = 1'b1;
        end
    end

    matrix_bank_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(waddr),
        .wdata(wdata),
        .re   (re),
        .raddr(raddr),
        .rdata(ram_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_INIT;
            cnt        <= '0;
            for (int i = 0; i < NUM_MAT; i++) begin
                dim_rows[i] <= IDX_W'(MAX_DIM);
                dim_cols[i] <= IDX_W'(MAX_DIM);
            end
            op_sel     <= '0;
            op_rows    <= '0;
            op_cols    <= '0;
            s_r        <= '0;
            s_c        <= '0;
            s_more     <= 1'b0;
            f_vld      <= 1'b0;
            f_last     <= 1'b0;
            rd_pend    <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            strm_data  <= '0;
            strm_valid <= 1'b0;
            strm_last  <= 1'b0;
            err        <= 1'b0;
        end else begin
            err      <= err_next;
            rd_pend  <= acc_elem & rd_en;
            rd_valid <= rd_pend;
            if (rd_pend) rd_data <= ram_q;

            case (state)
                ST_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (acc_clr) begin
                        op_sel <= sel;
                        cnt    <= '0;
                        state  <= ST_CLEAR;
                    end else if (acc_strm) begin
                        // Element (0,0) is fetched in this cycle; pointer moves to the next one.
                        op_sel  <= sel;
                        op_rows <= cur_rows;
                        op_cols <= cur_cols;
                        f_vld   <= 1'b1;
                        f_last  <= (cur_rows == IDX_W'(1)) && (cur_cols == IDX_W'(1));
                        s_more  <= !((cur_rows == IDX_W'(1)) && (cur_cols == IDX_W'(1)));
                        if (cur_cols == IDX_W'(1)) begin
                            s_r <= IDX_W'(1);
                            s_c <= '0;
                        end else begin
                            s_r <= '0;
                            s_c <= IDX_W'(1);
                        end
                        state <= ST_STREAM;
                    end else if (acc_cfg) begin
                        dim_rows[sel_i] <= cfg_rows;
                        dim_cols[sel_i] <= cfg_cols;
                    end
                end
                ST_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == ADDR_W'(MAX_DIM * MAX_DIM - 1)) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    if (s_issue) begin
                        f_last <= s_lastpos;
                        s_more <= !s_lastpos;
                        if (s_c == op_cols - 1'b1) begin
                            s_c <= '0;
                            s_r <= s_r + 1'b1;
                        end else begin
                            s_c <= s_c + 1'b1;
                        end
                    end
                    f_vld <= s_issue | (f_vld & !out_load);
                    if (out_load) begin
                        strm_data  <= ram_q;
                        strm_valid <= 1'b1;
                        strm_last  <= f_last;
                    end else if (out_fire) begin
                        strm_valid <= 1'b0;
                        strm_last  <= 1'b0;
                    end
                    if (out_fire && strm_last) state <= ST_IDLE;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_bank.sv
// Directed bench for matrix_bank: init timing, element access, bounds errors,
// streaming with backpressure, clear engine and reset abort.
module tb_matrix_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sel;
    logic [3:0] row, col, cfg_rows, cfg_cols;
    logic       wr_en, rd_en, cfg_en, clr_req, strm_start, strm_ready;
    logic [7:0] wr_data, rd_data, strm_data;
    logic       rd_valid, strm_valid, strm_last, busy, err;

    int tests = 0;
    int fails = 0;

    matrix_bank dut (
        .clk(clk), .reset(reset), .sel(sel), .row(row), .col(col),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .cfg_en(cfg_en), .cfg_rows(cfg_rows),
        .cfg_cols(cfg_cols), .clr_req(clr_req), .strm_start(strm_start),
        .strm_data(strm_data), .strm_valid(strm_valid), .strm_ready(strm_ready),
        .strm_last(strm_last), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; DUT samples them at the next rising edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_write(input logic [1:0] s, input logic [3:0] r, input logic [3:0] c,
                            input logic [7:0] d, output logic e);
        sel = s; row = r; col = c; wr_data = d; wr_en = 1'b1;
        cyc();
        wr_en = 1'b0;
        e = err;
    endtask

    task automatic do_read(input logic [1:0] s, input logic [3:0] r, input logic [3:0] c,
                           output logic [7:0] d, output logic v, output logic e);
        sel = s; row = r; col = c; rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        e = err;
        cyc();
        d = rd_data;
        v = rd_valid;
    endtask

    task automatic do_cfg(input logic [1:0] s, input logic [3:0] r, input logic [3:0] c,
                          output logic e);
        sel = s; cfg_rows = r; cfg_cols = c; cfg_en = 1'b1;
        cyc();
        cfg_en = 1'b0;
        e = err;
    endtask

    initial begin
        logic [7:0] d, prev_d;
        logic       v, e, prev_stall;
        int         n, k;

        reset = 1'b1; sel = '0; row = '0; col = '0; wr_en = 1'b0; rd_en = 1'b0;
        wr_data = '0; cfg_en = 1'b0; cfg_rows = '0; cfg_cols = '0; clr_req = 1'b0;
        strm_start = 1'b0; strm_ready = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_busy", busy, 1);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_strm_valid", strm_valid, 0);
        chk("rst_strm_data", strm_data, 0);
        chk("rst_strm_last", strm_last, 0);
        chk("rst_err", err, 0);

        // INIT sweeps 300 words
        reset = 1'b0;
        n = 0;
        while (busy && n < 400) begin cyc(); n++; end
        chk("init_cycles", n, 300);

        do_read(2'd2, 4'd9, 4'd9, d, v, e);
        chk("init_rd_err", e, 0);
        chk("init_rd_valid", v, 1);
        chk("init_rd_data", d, 8'h00);
        cyc();
        chk("rd_valid_pulse", rd_valid, 0);

        do_write(2'd1, 4'd2, 4'd3, 8'hA5, e);
        chk("wr_err", e, 0);
        do_read(2'd1, 4'd2, 4'd3, d, v, e);
        chk("rd_after_wr_valid", v, 1);
        chk("rd_after_wr_data", d, 8'hA5);

        do_cfg(2'd1, 4'd3, 4'd3, e);
        chk("cfg_ok_err", e, 0);
        do_read(2'd1, 4'd9, 4'd9, d, v, e);
        chk("oob_rd_err", e, 1);
        chk("oob_rd_valid", v, 0);
        chk("oob_err_pulse", err, 0);
        do_cfg(2'd0, 4'd0, 4'd3, e);
        chk("cfg_zero_err", e, 1);
        do_cfg(2'd0, 4'd11, 4'd3, e);
        chk("cfg_big_err", e, 1);

        // Matrix 0 as 2x3 holding 1..6 row-major
        do_cfg(2'd0, 4'd2, 4'd3, e);
        chk("cfg0_err", e, 0);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++)
                do_write(2'd0, 4'(r), 4'(c), 8'(r * 3 + c + 1), e);

        sel = 2'd0; strm_start = 1'b1;
        cyc();
        strm_start = 1'b0;
        chk("strm_busy", busy, 1);
        k = 0; prev_stall = 1'b0; prev_d = '0;
        for (int i = 0; i < 40 && k < 6; i++) begin
            strm_ready = i[0];
            if (strm_valid) begin
                chk("strm_data", strm_data, 32'(k + 1));
                chk("strm_last", strm_last, (k == 5) ? 1 : 0);
                if (prev_stall) chk("strm_stable", strm_data, prev_d);
                prev_stall = !strm_ready;
                prev_d = strm_data;
                if (strm_ready) k++;
            end else begin
                prev_stall = 1'b0;
            end
            cyc();
        end
        strm_ready = 1'b0;
        chk("strm_count", k, 6);
        chk("strm_done_busy", busy, 0);
        chk("strm_done_valid", strm_valid, 0);

        // Clear matrix 1 after filling corners
        do_cfg(2'd1, 4'd10, 4'd10, e);
        do_write(2'd1, 4'd9, 4'd9, 8'h5A, e);
        sel = 2'd1; clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        n = 0;
        while (busy && n < 200) begin cyc(); n++; end
        chk("clr_cycles", n, 100);
        do_read(2'd1, 4'd2, 4'd3, d, v, e);
        chk("clr_rd_a", d, 8'h00);
        do_read(2'd1, 4'd9, 4'd9, d, v, e);
        chk("clr_rd_b", d, 8'h00);
        chk("clr_rd_b_valid", v, 1);
        do_read(2'd0, 4'd1, 4'd2, d, v, e);
        chk("clr_m0_intact", d, 8'h06);

        // Requests while streaming are rejected
        sel = 2'd0; strm_start = 1'b1;
        cyc();
        strm_start = 1'b0;
        do_write(2'd0, 4'd0, 4'd0, 8'hFF, e);
        chk("busy_wr_err", e, 1);
        cyc();
        chk("busy_err_pulse", err, 0);
        strm_ready = 1'b1;
        n = 0;
        while (busy && n < 30) begin cyc(); n++; end
        strm_ready = 1'b0;
        chk("strm2_done", busy, 0);
        do_write(2'd3, 4'd0, 4'd0, 8'hFF, e);
        chk("sel3_err", e, 1);
        do_read(2'd0, 4'd0, 4'd0, d, v, e);
        chk("mem_unchanged", d, 8'h01);

        // Reset aborts a clear in flight
        do_read(2'd0, 4'd1, 4'd2, d, v, e);
        chk("pre_rst_rd", d, 8'h06);
        sel = 2'd2; clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        repeat (5) cyc();
        chk("mid_clr_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("arst_rd_data", rd_data, 0);
        chk("arst_busy", busy, 1);
        chk("arst_err", err, 0);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (busy && n < 400) begin cyc(); n++; end
        chk("reinit_cycles", n, 300);
        do_read(2'd0, 4'd9, 4'd9, d, v, e);
        chk("dims_reset_err", e, 0);
        chk("dims_reset_valid", v, 1);
        chk("reinit_data", d, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
